// File: rtl/mac_stream.sv
// mac_stream: streaming multiply-accumulate over N = B/W lanes.
// A frame begins with start in IDLE. Each accepted beat forms a dot product
// of its lanes with the latched coefficients. The dot product is then added
// into an ACC_W accumulator, which either wraps or saturates.
// The frame result is held on m_axis_* until it is consumed.
//
// Handshakes: a transfer on either stream happens in a cycle where that
// stream's tvalid and tready are both high. On the input side, tready is a
// register that is high exactly in RUN. On the output side, tvalid is high
// exactly in DONE. tdata does not change while tvalid is high and tready is low.
module mac_stream #(
    parameter int B     = 64,
    parameter int W     = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [B-1:0]     s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [B-1:0]     coef,
    input  logic             mode_signed,
    input  logic             mode_sat,
    output logic [ACC_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             ovf
);

    localparam int N   = B / W;
    localparam int LN  = $clog2(N);
    // Width of the exact stage-1 sum. Each lane product occupies 2W bits.
    localparam int P_W = 2 * W + LN;
    // Width of the exact stage-2 sum.
    localparam int S_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic               tready_q;
    logic               drain_cnt;
    logic [CNT_W-1:0]   len_q;
    logic [B-1:0]       coef_q;
    logic               signed_q;
    logic               sat_q;
    logic               s1_valid;
    logic [P_W-1:0]     s1_sum;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic               accept;
    logic               terminate;
    logic               frame_start;
    logic [CNT_W-1:0]   cnt_inc;

    assign frame_start = (state == IDLE) && start;
    assign accept      = s_axis_tvalid && tready_q;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign terminate   = accept && (s_axis_tlast || ((len_q != '0) && (cnt_inc == len_q)));

    // Next-state logic for the frame FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (terminate) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = DONE;
            DONE:    if (m_axis_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, registered input ready, and drain cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tready_q  <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            tready_q  <= (state_next == RUN);
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Frame configuration is captured once, when the frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            coef_q   <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else if (frame_start) begin
            len_q    <= len;
            coef_q   <= coef;
            signed_q <= mode_signed;
            sat_q    <= mode_sat;
        end
    end

    // Stage-1 dot product.
    // Operands are extended straight to the sum width, and the arithmetic is
    // done modulo 2^P_W. The true sum always fits in P_W bits when read in
    // the frame's mode, so the result is exact.
    logic [P_W-1:0] lane_x, coef_x, prod, dot;
    always_comb begin
        dot    = '0;
        lane_x = '0;
        coef_x = '0;
        prod   = '0;
        for (int i = 0; i < N; i++) begin
            if (signed_q) begin
                lane_x = P_W'($signed(s_axis_tdata[i*W +: W]));
                coef_x = P_W'($signed(coef_q[i*W +: W]));
            end else begin
                lane_x = P_W'(s_axis_tdata[i*W +: W]);
                coef_x = P_W'(coef_q[i*W +: W]);
            end
            prod = lane_x * coef_x;
            dot  = dot + prod;
        end
    end

    // Stage-1 pipeline register, loaded on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_sum <= dot;
        end
    end

    // Stage-2 exact addition, followed by range check and reduction to ACC_W bits.
    logic [S_W-1:0]   acc_x, s1_x, sum_x;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sat_val;
    logic             ovf_now;
    always_comb begin
        if (signed_q) begin
            acc_x   = S_W'($signed(acc));
            s1_x    = S_W'($signed(s1_sum));
        end else begin
            acc_x   = S_W'(acc);
            s1_x    = S_W'(s1_sum);
        end
        sum_x = acc_x + s1_x;
        if (signed_q) begin
            // In range only if every bit from the ACC_W sign bit upward matches.
            ovf_now = !((&sum_x[S_W-1:ACC_W-1]) || !(|sum_x[S_W-1:ACC_W-1]));
            sat_val = sum_x[S_W-1] ? SMIN : SMAX;
        end else begin
            // An unsigned sum can only overflow upward.
            ovf_now = |sum_x[S_W-1:ACC_W];
            sat_val = UMAX;
        end
        acc_next = (ovf_now && sat_q) ? sat_val : sum_x[ACC_W-1:0];
    end

    // Accumulator and sticky overflow. Both are cleared only by a new frame or by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (frame_start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (s1_valid) begin
            acc <= acc_next;
            if (ovf_now) ovf_q <= 1'b1;
        end
    end

    // Count of accepted beats. With len=0 the counter wraps and the frame continues.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (frame_start) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_inc;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (state == DONE);
    assign m_axis_tdata  = acc;
    assign busy          = (state != IDLE);
    assign beat_cnt      = cnt_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: drives two mac_stream instances with the same stimulus.
// Instance a uses ACC_W=32 and CNT_W=16. Instance b uses ACC_W=16 and
// CNT_W=4, which exposes overflow and counter wrap. Both are compared
// against a frame-level arithmetic model kept in this file.
module tb_mac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        start;
    logic [15:0] len;
    logic [63:0] coef;
    logic        mode_signed;
    logic        mode_sat;
    logic        m_tready;

    logic        a_tready, a_tvalid, a_busy, a_ovf;
    logic [31:0] a_tdata;
    logic [15:0] a_cnt;
    logic        b_tready, b_tvalid, b_busy, b_ovf;
    logic [15:0] b_tdata;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] beat_q[$];
    logic [63:0] cur_coef;

    // Clock and DUT instances.
    always #5 clk = ~clk;

    mac_stream #(.B(64), .W(8), .ACC_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready),
        .s_axis_tlast(s_tlast), .start(start), .len(len), .coef(coef),
        .mode_signed(mode_signed), .mode_sat(mode_sat),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .busy(a_busy), .beat_cnt(a_cnt), .ovf(a_ovf)
    );

    mac_stream #(.B(64), .W(8), .ACC_W(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready),
        .s_axis_tlast(s_tlast), .start(start), .len(len[3:0]), .coef(coef),
        .mode_signed(mode_signed), .mode_sat(mode_sat),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
        .busy(b_busy), .beat_cnt(b_cnt), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame model: each beat adds the exact dot product, then the result is
    // clamped or wrapped into the acc_w range for the frame's mode.
    task automatic model(input int acc_w, input bit sgn, input bit sat,
                         output logic [63:0] res, output bit ovf_o);
        longint acc, dot, dv, cv, lo, hi, span;
        logic [63:0] bt;
        logic [7:0]  d, c;
        span  = longint'(1) << acc_w;
        lo    = sgn ? -(span / 2) : 0;
        hi    = sgn ? (span / 2) - 1 : span - 1;
        acc   = 0;
        ovf_o = 1'b0;
        foreach (beat_q[j]) begin
            bt  = beat_q[j];
            dot = 0;
            for (int i = 0; i < 8; i++) begin
                d = bt[i*8 +: 8];
                c = cur_coef[i*8 +: 8];
                if (sgn) begin
                    dv = longint'($signed(d));
                    cv = longint'($signed(c));
                end else begin
                    dv = longint'(d);
                    cv = longint'(c);
                end
                dot += dv * cv;
            end
            acc += dot;
            if (acc > hi || acc < lo) begin
                ovf_o = 1'b1;
                if (sat) acc = (acc > hi) ? hi : lo;
                else begin
                    acc = acc & (span - 1);
                    if (sgn && acc > hi) acc -= span;
                end
            end
        end
        res = 64'(acc) & 64'(span - 1);
    endtask

    task automatic do_reset();
        s_tvalid = 0; s_tlast = 0; start = 0; m_tready = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // Driver for one complete frame, from start through the output handshake.
    task automatic run_frame(input int flen, input logic [63:0] fcoef, input bit fms, input bit fsat,
                             input int tlast_at, input bit stall, input bit rnd,
                             input logic [63:0] fdata, input int hold, input bit poke);
        int term;
        logic [63:0] d, ra, rb, a_hold, b_hold;
        bit oa, ob;
        term = (flen == 0 || (tlast_at >= 0 && tlast_at < flen)) ? tlast_at : flen - 1;
        beat_q.delete();
        cur_coef = fcoef;
        @(negedge clk);
        start = 1; len = 16'(flen); coef = fcoef; mode_signed = fms; mode_sat = fsat;
        @(negedge clk);
        // Change the configuration inputs during the frame; the DUT must keep the values it latched at start.
        start = 0; len = 16'($urandom); coef = {$urandom, $urandom};
        mode_signed = ~fms; mode_sat = ~fsat;
        for (int b = 0; b <= term; b++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    s_tvalid = 0; s_tdata = {$urandom, $urandom};
                    @(negedge clk);
                end
            end
            d = rnd ? {$urandom, $urandom} : fdata;
            check("tready_run", {a_tready, b_tready}, 2'b11);
            s_tdata = d; s_tvalid = 1; s_tlast = (b == tlast_at);
            beat_q.push_back(d);
            @(negedge clk);
        end
        s_tvalid = 0; s_tlast = 0;
        check("tready_after_last", {a_tready, b_tready}, 2'b00);
        check("busy_drain", {a_busy, b_busy}, 2'b11);
        check("tvalid_k1", {a_tvalid, b_tvalid}, 2'b00);
        @(negedge clk);
        check("tvalid_k2", {a_tvalid, b_tvalid}, 2'b00);
        @(negedge clk);
        check("tvalid_k3", {a_tvalid, b_tvalid}, 2'b11);
        if (!a_tvalid) begin
            for (int t = 0; t < 20 && !a_tvalid; t++) @(negedge clk);
            check("done_timeout", a_tvalid, 1);
            if (!a_tvalid) begin
                do_reset();
                return;
            end
        end
        model(32, fms, fsat, ra, oa);
        model(16, fms, fsat, rb, ob);
        check("a_tdata", a_tdata, ra);
        check("b_tdata", b_tdata, rb);
        check("a_ovf", a_ovf, oa);
        check("b_ovf", b_ovf, ob);
        check("a_beat_cnt", a_cnt, (term + 1) % 65536);
        check("b_beat_cnt", b_cnt, (term + 1) % 16);
        a_hold = a_tdata; b_hold = b_tdata;
        for (int h = 0; h < hold; h++) begin
            start = poke && (h == 1);
            @(negedge clk);
            start = 0;
            check("bp_tvalid", {a_tvalid, b_tvalid}, 2'b11);
            check("bp_a_tdata", a_tdata, a_hold);
            check("bp_b_tdata", b_tdata, b_hold);
        end
        m_tready = 1;
        @(negedge clk);
        m_tready = 0;
        check("idle_tvalid", {a_tvalid, b_tvalid}, 2'b00);
        check("idle_busy", {a_busy, b_busy}, 2'b00);
        @(negedge clk);
        check("idle_a_tdata", a_tdata, ra);
        check("idle_b_tdata", b_tdata, rb);
        check("idle_a_cnt", a_cnt, (term + 1) % 65536);
        check("idle_ovf", {a_ovf, b_ovf}, {oa, ob});
    endtask

    // Test sequence.
    initial begin
        s_tdata = '0; len = '0; coef = '0; mode_signed = 0; mode_sat = 0;
        do_reset();
        @(negedge clk);
        check("rst_busy", {a_busy, b_busy}, 2'b00);
        check("rst_tready", {a_tready, b_tready}, 2'b00);
        check("rst_tvalid", {a_tvalid, b_tvalid}, 2'b00);
        check("rst_a_tdata", a_tdata, 0);
        check("rst_cnt_ovf", {a_cnt, b_cnt, a_ovf, b_ovf}, 0);

        // Signed: -1 times 1 across 8 lanes and 4 beats gives -32.
        run_frame(4, 64'h0101010101010101, 1, 0, -1, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0);
        check("r31_tdata", a_tdata, 32'hFFFFFFE0);
        check("r31_cnt", a_cnt, 4);
        check("r31_ovf", a_ovf, 0);
        // Same stimulus, unsigned: 255 * 8 * 4 = 8160.
        run_frame(4, 64'h0101010101010101, 0, 0, -1, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0);
        check("r32_tdata", a_tdata, 32'h00001FE0);
        check("r32_ovf", a_ovf, 0);
        // tlast arrives on beat 2 of a len=10 frame.
        run_frame(10, {$urandom, $urandom}, 1, 1, 1, 1, 1, '0, 0, 0);
        check("r33_cnt", a_cnt, 2);
        // 16-bit accumulator overflow, first saturating, then wrapping.
        run_frame(1, 64'h7F7F7F7F7F7F7F7F, 1, 1, -1, 0, 0, 64'h7F7F7F7F7F7F7F7F, 0, 0);
        check("r34_sat_tdata", b_tdata, 16'h7FFF);
        check("r34_sat_ovf", b_ovf, 1);
        run_frame(1, 64'h7F7F7F7F7F7F7F7F, 1, 0, -1, 0, 0, 64'h7F7F7F7F7F7F7F7F, 0, 0);
        check("r34_wrap_tdata", b_tdata, 16'hF808);
        check("r34_wrap_ovf", b_ovf, 1);
        // Output backpressure for 5 cycles, with start pulsed while in DONE.
        run_frame(3, {$urandom, $urandom}, 0, 0, -1, 1, 1, '0, 5, 1);

        // Reset in the middle of a frame, after its second beat.
        @(negedge clk);
        start = 1; len = 8; coef = {$urandom, $urandom}; mode_signed = 1; mode_sat = 0;
        @(negedge clk);
        start = 0;
        repeat (2) begin
            s_tdata = {$urandom, $urandom}; s_tvalid = 1;
            @(negedge clk);
        end
        s_tvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("r36_busy", {a_busy, b_busy}, 2'b00);
        check("r36_tready", {a_tready, b_tready}, 2'b00);
        check("r36_cnt", {a_cnt, b_cnt}, 0);
        check("r36_tdata", {a_tdata, b_tdata}, 0);
        repeat (4) begin
            @(negedge clk);
            check("r36_no_tvalid", {a_tvalid, b_tvalid}, 2'b00);
        end
        run_frame(8, {$urandom, $urandom}, 1, 0, -1, 1, 1, '0, 1, 0);

        // With len=0, 18 beats wrap the 4-bit counter of instance b.
        run_frame(0, {$urandom, $urandom}, 0, 1, 17, 0, 1, '0, 0, 0);
        check("wrap_b_cnt", b_cnt, 2);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int fl, tl;
            fl = $urandom_range(0, 15);
            tl = (fl == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
            run_frame(fl, {$urandom, $urandom}, 1'($urandom), 1'($urandom), tl,
                      1'($urandom), 1, '0, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_stream.md
MAC_STREAM -- requirements
Module: mac_stream

Interface
REQ-001 SHALL have parameter B, default 64: input bus width in bits; SHALL be a multiple of W.
REQ-002 SHALL have parameter W, default 8: lane width; lane count N = B/W, a power of 2, at least 2.
REQ-003 SHALL have parameter ACC_W, default 32: accumulator and result width.
REQ-004 SHALL have parameter CNT_W, default 16: beat-counter width.
REQ-005 SHALL use one clock; reset SHALL be synchronous, active-high.
REQ-006 Ports:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - s_axis_tdata  in  B  lane i = bits [i*W +: W]
  - s_axis_tvalid  in  1  input beat valid
  - s_axis_tready  out  1  input beat accepted when high with tvalid
  - s_axis_tlast  in  1  early frame end
  - start  in  1  single-cycle frame start
  - len  in  CNT_W  beats per frame; 0 means end on tlast only
  - coef  in  B  per-lane weights, same lane layout as s_axis_tdata
  - mode_signed  in  1  1 = lanes and coefs are two's complement; 0 = unsigned
  - mode_sat  in  1  1 = saturate accumulator; 0 = wrap
  - m_axis_tdata  out  ACC_W  frame result
  - m_axis_tvalid  out  1  result valid
  - m_axis_tready  in  1  result consumed
  - busy  out  1  state is not IDLE
  - beat_cnt  out  CNT_W  beats accepted in the current or last frame
  - ovf  out  1  sticky overflow for the current or last frame

Function
REQ-007 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-008 IDLE with start=1 SHALL: latch len, coef, mode_signed and mode_sat; clear accumulator, beat_cnt and ovf; go to RUN.
REQ-009 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-010 s_axis_tready SHALL equal (state==RUN), driven from a register; it SHALL be 0 in all other states.
REQ-011 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both 1; each accepted beat SHALL increment beat_cnt by 1.
REQ-012 The terminating beat SHALL be the accepted beat with tlast=1, or the beat that makes beat_cnt equal latched len when len is nonzero, whichever comes first.
REQ-013 After the terminating beat the state SHALL go to DRAIN, so s_axis_tready is 0 in the next cycle.
REQ-014 Pipeline stage 1, registered the cycle after acceptance, SHALL hold the sum over i of lane_i*coef_i.
REQ-015 Each stage-1 product SHALL be 2W bits wide; the stage-1 sum SHALL be 2W+log2(N) bits, exact with no truncation.
REQ-016 Stage-1 operands SHALL be sign- or zero-extended per latched mode_signed.
REQ-017 Stage 2, one cycle after stage 1, SHALL add the stage-1 sum into the accumulator.
REQ-018 Stage-2 addition SHALL be computed at max(ACC_W, 2W+log2(N))+1 bits and then reduced to ACC_W.
REQ-019 Reduction with mode_sat=1 SHALL clamp to the ACC_W range: signed limits in signed mode, 0 to 2^ACC_W-1 in unsigned mode.
REQ-020 Reduction with mode_sat=0 SHALL keep the low ACC_W bits (wrap).
REQ-021 ovf SHALL set whenever the exact result falls outside the ACC_W range, in either mode; it SHALL stay set until the next accepted start.
REQ-022 DRAIN SHALL last exactly 2 cycles, until the last beat has reached the accumulator, then go to DONE.
REQ-023 Latency: terminating beat accepted in cycle k gives m_axis_tvalid=1 in cycle k+3.
REQ-024 DONE SHALL hold m_axis_tvalid=1 and m_axis_tdata equal to the accumulator.
REQ-025 In DONE, tdata SHALL stay stable while m_axis_tready=0; in a cycle with tvalid and tready both 1 the next state SHALL be IDLE.
REQ-026 In IDLE, m_axis_tvalid SHALL be 0; m_axis_tdata, beat_cnt and ovf SHALL keep the last frame's values until the next start.
REQ-027 Input stalls (tvalid=0 in RUN) SHALL neither advance the counter nor add to the accumulator.
REQ-028 When the counter is at 2^CNT_W-1 with len=0, the next accepted beat SHALL wrap beat_cnt to 0 and the frame SHALL continue.

Reset
REQ-029 rst=1 SHALL, at the next clk edge and from any state: set state to IDLE; zero the accumulator, pipeline registers, beat_cnt, ovf, m_axis_tdata, m_axis_tvalid, s_axis_tready and busy.
REQ-030 rst SHALL take priority over start and all handshakes; a frame in progress SHALL be discarded with no output.

Verification (B=64, W=8 unless noted)
REQ-031 Signed, all-ones result: signed, coef bytes all 0x01, len=4, data bytes 0xFF -> tdata=0xFFFFFFE0 (-32), beat_cnt=4, ovf=0, tvalid 3 cycles after the 4th beat.
REQ-032 Unsigned, same stimulus as REQ-031 with mode_signed=0 -> tdata=0x00001FE0 (8160), ovf=0.
REQ-033 tlast before len: len=10, tlast on beat 2 -> beat_cnt=2; s_axis_tready=0 from the cycle after beat 2; result covers 2 beats only.
REQ-034 Overflow with ACC_W=16: signed, coef and data bytes 0x7F, len=1.
  - mode_sat=1 -> tdata=0x7FFF, ovf=1.
  - mode_sat=0 -> tdata=0xF808, ovf=1.
REQ-035 Output backpressure: m_axis_tready=0 for 5 cycles in DONE, start pulsed during this time -> tvalid and tdata stable, start ignored, IDLE one cycle after tready=1.
REQ-036 Reset mid-frame: rst pulsed after beat 2 of a len=8 frame -> next cycle busy=0, s_axis_tready=0, beat_cnt=0, tdata=0, no tvalid; a new start then runs correctly.
